// File: rtl/jit_pkg.sv
// Shared types and constants for the JIT code-emission sequencer.
package jit_pkg;

  localparam int ROM_AW = 7;
  localparam int ROM_DW = 32;
  localparam logic [ROM_DW-1:0] ROM_ERR_WORD = 32'hFFFF_FFFF;

  // ARM BL: condition field is don't-care, opcode nibble 1011 at [27:24]
  localparam logic [ROM_DW-1:0] BL_MASK  = 32'h0F00_0000;
  localparam logic [ROM_DW-1:0] BL_MATCH = 32'h0B00_0000;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } emit_state_t;

  function automatic logic is_bl(input logic [ROM_DW-1:0] w);
    return (w & BL_MASK) == BL_MATCH;
  endfunction

endpackage

// File: rtl/jit_bl_fixup.sv
// Rewrites the 24-bit offset of a BL word so it branches from its own code-buffer
// address to the requested target word (ARM PC is two words ahead).
module jit_bl_fixup
  import jit_pkg::*;
#(
  parameter int AW = 10
) (
  input  logic [ROM_DW-1:0] i_word,
  input  logic [AW-1:0]     i_addr,
  input  logic [AW-1:0]     i_target,
  output logic [ROM_DW-1:0] o_word
);

  logic [AW-1:0] w_diff;
  logic [23:0]   w_off;

  assign w_diff = i_target - (i_addr + AW'(2));
  assign w_off  = 24'($signed(w_diff));
  assign o_word = is_bl(i_word) ? {i_word[31:24], w_off} : i_word;

endmodule

// File: rtl/jit_emit_seq.sv
// JIT emission sequencer: walks com_rom template words, patches and streams them.
// Optional BL offset fixup is built when JIT_EMIT_BRANCH_FIXUP_EN is defined.
module jit_emit_seq
  import jit_pkg::*;
#(
  parameter int AW   = 10,
  parameter int LENW = 4
) (
  input  logic              i_clk,
  input  logic              i_reset_n,
  input  logic              i_cmd_valid,
  output logic              o_cmd_ready,
  input  logic [ROM_AW-1:0] i_cmd_base,
  input  logic [LENW-1:0]   i_cmd_len,
  input  logic [11:0]       i_cmd_imm,
  input  logic              i_cmd_patch,
  input  logic [LENW-1:0]   i_cmd_pidx,
  input  logic [AW-1:0]     i_cmd_target,
  input  logic              i_flush,
  output logic [ROM_AW-1:0] o_rom_addr,
  input  logic [ROM_DW-1:0] i_rom_data,
  output logic              o_out_valid,
  input  logic              i_out_ready,
  output logic [ROM_DW-1:0] o_out_data,
  output logic [AW-1:0]     o_out_addr,
  output logic              o_done,
  output logic              o_err,
  output logic              o_ovf
);

  emit_state_t       r_state;
  logic [ROM_AW-1:0] r_base;
  logic [LENW-1:0]   r_len;
  logic [LENW-1:0]   r_pidx;
  logic [LENW-1:0]   r_idx;
  logic [11:0]       r_imm;
  logic              r_patch;
  logic [AW-1:0]     r_ptr;
  logic              r_out_valid;
  logic [ROM_DW-1:0] r_out_data;
  logic [AW-1:0]     r_out_addr;
  logic              r_done;
  logic              r_err;
  logic              r_ovf;

  logic              w_idle;
  logic              w_accept;
  logic [ROM_AW-1:0] w_base;
  logic [LENW-1:0]   w_len;
  logic [LENW-1:0]   w_pidx;
  logic [LENW-1:0]   w_idx;
  logic [11:0]       w_imm;
  logic              w_patch;
  logic              w_issue;
  logic              w_hs;
  logic              w_slot;
  logic              w_bad;
  logic              w_load;
  logic              w_last;
  logic [AW-1:0]     w_ptr;
  logic [AW-1:0]     w_load_addr;
  logic [ROM_DW-1:0] w_patched;
  logic [ROM_DW-1:0] w_word;

  // In IDLE the live command fields drive the datapath so word 0 loads on accept.
  assign w_idle   = (r_state == IDLE);
  assign w_accept = w_idle & i_cmd_valid;
  assign w_base   = w_idle ? i_cmd_base  : r_base;
  assign w_len    = w_idle ? i_cmd_len   : r_len;
  assign w_pidx   = w_idle ? i_cmd_pidx  : r_pidx;
  assign w_imm    = w_idle ? i_cmd_imm   : r_imm;
  assign w_patch  = w_idle ? i_cmd_patch : r_patch;
  assign w_idx    = w_idle ? '0 : r_idx;

  assign o_rom_addr = w_base + ROM_AW'(w_idx);

  assign w_issue = (w_accept & (i_cmd_len != '0)) | (r_state == RUN);
  assign w_hs    = r_out_valid & i_out_ready;
  assign w_slot  = ~r_out_valid | i_out_ready;
  assign w_bad   = (i_rom_data == ROM_ERR_WORD);
  assign w_load  = w_issue & w_slot & ~w_bad;
  assign w_last  = (w_idx == (w_len - 1'b1));

  // While a word is held its address equals r_ptr, so a replacing word goes one past it.
  assign w_ptr       = (w_idle & i_flush) ? '0 : r_ptr;
  assign w_load_addr = w_hs ? (r_ptr + AW'(1)) : w_ptr;

  assign w_patched = i_rom_data |
                     ((w_patch && (w_idx == w_pidx)) ? {20'b0, w_imm} : '0);

`ifdef JIT_EMIT_BRANCH_FIXUP_EN
  logic [AW-1:0] r_target;
  logic [AW-1:0] w_target;

  assign w_target = w_idle ? i_cmd_target : r_target;

  always_ff @(posedge i_clk) begin
    if (!i_reset_n)    r_target <= '0;
    else if (w_accept) r_target <= i_cmd_target;
  end

  jit_bl_fixup #(.AW(AW)) u_fixup (
    .i_word   (w_patched),
    .i_addr   (w_load_addr),
    .i_target (w_target),
    .o_word   (w_word)
  );
`else
  logic w_unused_target;
  assign w_unused_target = ^i_cmd_target;
  assign w_word          = w_patched;
`endif

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      r_state     <= IDLE;
      r_base      <= '0;
      r_len       <= '0;
      r_pidx      <= '0;
      r_idx       <= '0;
      r_imm       <= '0;
      r_patch     <= 1'b0;
      r_ptr       <= '0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_addr  <= '0;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
      r_ovf       <= 1'b0;
    end else begin
      r_done <= 1'b0;
      r_err  <= 1'b0;

      if (w_hs) begin
        r_ptr       <= r_ptr + AW'(1);
        r_out_valid <= 1'b0;
        if (&r_ptr) r_ovf <= 1'b1;
      end
      if (w_idle & i_flush) begin
        r_ptr <= '0;
        r_ovf <= 1'b0;
      end

      if (w_load) begin
        r_out_valid <= 1'b1;
        r_out_data  <= w_word;
        r_out_addr  <= w_load_addr;
        r_idx       <= w_idx + 1'b1;
      end

      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_base  <= i_cmd_base;
            r_len   <= i_cmd_len;
            r_pidx  <= i_cmd_pidx;
            r_imm   <= i_cmd_imm;
            r_patch <= i_cmd_patch;
            if (i_cmd_len == '0) begin
              r_done <= 1'b1;
            end else if (w_bad) begin
              r_err  <= 1'b1;
              r_done <= 1'b1;
            end else begin
              r_state <= w_last ? DRAIN : RUN;
            end
          end
        end
        RUN: begin
          // An invalid word aborts the rest; a stalled held word still drains.
          if (w_bad) begin
            r_err <= 1'b1;
            if (r_out_valid & ~i_out_ready) begin
              r_state <= DRAIN;
            end else begin
              r_state <= IDLE;
              r_done  <= 1'b1;
            end
          end else if (w_load & w_last) begin
            r_state <= DRAIN;
          end
        end
        DRAIN: begin
          if (w_hs) r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign o_cmd_ready = w_idle;
  assign o_out_valid = r_out_valid;
  assign o_out_data  = r_out_data;
  assign o_out_addr  = r_out_addr;
  assign o_done      = r_done | ((r_state == DRAIN) & w_hs);
  assign o_err       = r_err;
  assign o_ovf       = r_ovf;

endmodule
